// File: rtl/cu_pipe_ctrl.sv
// cu_pipe_ctrl: parametrised in-order pipeline controller.
// Holds DEPTH instruction stages with per-stage valid bits.
// Stages advance under per-stage done handshakes.
// Issue (stage 0) is stalled while a register or flag hazard exists
// against any live later stage.
//
// Optional build macro: CU_PIPE_WB_BYPASS_EN
//   When defined, the writeback stage (DEPTH-1) is left out of the register
//   hazard check, because the write-through register file makes its result
//   visible to stage 0 in the same cycle. Flag hazards always include every
//   later stage.

module cu_pipe_ctrl #(
    parameter int IW    = 24,
    parameter int DEPTH = 3,
    parameter int NREG  = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IW-1:0]         in_instr,
    input  logic [NREG-1:0]       in_rmask,
    input  logic [NREG-1:0]       in_wmask,
    input  logic                  in_fuse,
    input  logic                  in_fset,

    input  logic [DEPTH-1:0]      stage_done,
    input  logic                  flush,

    output logic [DEPTH*IW-1:0]   stage_instr,
    output logic [DEPTH-1:0]      stage_valid,
    output logic                  issue_go,
    output logic                  hazard,
    output logic                  retire
);

    // Highest stage index that still takes part in the register hazard.
`ifdef CU_PIPE_WB_BYPASS_EN
    localparam int RegHazLast = DEPTH - 2;
`else
    localparam int RegHazLast = DEPTH - 1;
`endif

    // ------------------------------------------------------------------
    // Stage state. Read mask and flag-use only matter while an instruction
    // sits in issue, so they are held for stage 0 only; write mask and
    // flag-set travel with the instruction down the pipe.
    // ------------------------------------------------------------------
    logic [DEPTH-1:0][IW-1:0]   instr_q, instr_d;
    logic [DEPTH-1:0][NREG-1:0] wmask_q, wmask_d;
    logic [DEPTH-1:0]           fset_q,  fset_d;
    logic [DEPTH-1:0]           valid_q, valid_d;
    logic [NREG-1:0]            rmask_q, rmask_d;
    logic                       fuse_q,  fuse_d;

    logic [NREG-1:0]            reg_busy;
    logic                       flag_busy;
    logic                       reg_haz;
    logic                       flag_haz;
    logic [DEPTH-1:0]           adv;
    logic                       load;

    // Collect the registers and flags still pending in live later stages.
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no
        // path through the block can leave it unassigned and infer a latch.
        reg_busy  = '0;
        flag_busy = 1'b0;
        for (int k = 1; k < DEPTH; k++) begin
            if (valid_q[k] && (k <= RegHazLast)) begin
                reg_busy = reg_busy | wmask_q[k];
            end
            if (valid_q[k]) begin
                flag_busy = flag_busy | fset_q[k];
            end
        end
    end

    assign reg_haz  = |(rmask_q & reg_busy);
    assign flag_haz = fuse_q & flag_busy;
    assign hazard   = valid_q[0] & (reg_haz | flag_haz);
    assign issue_go = valid_q[0] & ~hazard & ~flush;

    // Advance chain, resolved from writeback down to issue: a stage may
    // move on only if the stage above it is empty or moving on as well.
    always_comb begin
        logic room_above;
        adv        = '0;
        room_above = 1'b1;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            adv[k]     = valid_q[k] & stage_done[k] & room_above;
            room_above = ~valid_q[k] | adv[k];
        end
        adv[0] = issue_go & stage_done[0] & room_above;
    end

    assign in_ready = ~flush & (~valid_q[0] | adv[0]);
    assign load     = in_valid & in_ready;

    // Next-state: shift advancing stages up, bubble out stages that left,
    // and capture the fetched instruction into issue.
    always_comb begin
        instr_d = instr_q;
        wmask_d = wmask_q;
        fset_d  = fset_q;
        valid_d = valid_q;
        rmask_d = rmask_q;
        fuse_d  = fuse_q;

        for (int k = 1; k < DEPTH; k++) begin
            if (adv[k-1]) begin
                instr_d[k] = instr_q[k-1];
                wmask_d[k] = wmask_q[k-1];
                fset_d[k]  = fset_q[k-1];
                valid_d[k] = 1'b1;
            end else if (adv[k]) begin
                valid_d[k] = 1'b0;
            end
        end

        // A flush never coincides with a load, since in_ready is low.
        if (load) begin
            instr_d[0] = in_instr;
            wmask_d[0] = in_wmask;
            fset_d[0]  = in_fset;
            rmask_d    = in_rmask;
            fuse_d     = in_fuse;
            valid_d[0] = 1'b1;
        end else if (adv[0] || flush) begin
            valid_d[0] = 1'b0;
        end
    end

    // Stage registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs regardless of statement order.
        if (rst) begin
            // NOTE: the per-stage payload is reset too, not just the valid
            // bits, so stage_instr reads as zero straight out of reset.
            instr_q <= '0;
            wmask_q <= '0;
            fset_q  <= '0;
            valid_q <= '0;
            rmask_q <= '0;
            fuse_q  <= 1'b0;
        end else begin
            instr_q <= instr_d;
            wmask_q <= wmask_d;
            fset_q  <= fset_d;
            valid_q <= valid_d;
            rmask_q <= rmask_d;
            fuse_q  <= fuse_d;
        end
    end

    // Packed stage array maps stage k onto bits [k*IW +: IW].
    assign stage_instr = instr_q;
    assign stage_valid = valid_q;
    assign retire      = adv[DEPTH-1];

endmodule

// File: tb/tb_cu_pipe_ctrl.sv
// Directed bench for cu_pipe_ctrl (DEPTH=3, IW=24, NREG=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled a
// further time unit later, well clear of the next edge.

module tb_cu_pipe_ctrl;

    localparam int IW    = 24;
    localparam int DEPTH = 3;
    localparam int NREG  = 8;

`ifdef CU_PIPE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [IW-1:0]       in_instr;
    logic [NREG-1:0]     in_rmask;
    logic [NREG-1:0]     in_wmask;
    logic                in_fuse;
    logic                in_fset;
    logic [DEPTH-1:0]    stage_done;
    logic                flush;
    logic [DEPTH*IW-1:0] stage_instr;
    logic [DEPTH-1:0]    stage_valid;
    logic                issue_go;
    logic                hazard;
    logic                retire;

    int checks = 0;
    int errors = 0;

    cu_pipe_ctrl #(.IW(IW), .DEPTH(DEPTH), .NREG(NREG)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_rmask    (in_rmask),
        .in_wmask    (in_wmask),
        .in_fuse     (in_fuse),
        .in_fset     (in_fset),
        .stage_done  (stage_done),
        .flush       (flush),
        .stage_instr (stage_instr),
        .stage_valid (stage_valid),
        .issue_go    (issue_go),
        .hazard      (hazard),
        .retire      (retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [IW-1:0] ins,
                         input logic [NREG-1:0] rm, input logic [NREG-1:0] wm,
                         input logic fu, input logic fs);
        in_valid = v;
        in_instr = ins;
        in_rmask = rm;
        in_wmask = wm;
        in_fuse  = fu;
        in_fset  = fs;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Let everything retire, bounded by a cycle budget.
    task automatic drain(input string tag);
        idle();
        flush      = 1'b0;
        stage_done = 3'b111;
        for (int i = 0; i < 10; i++) begin
            if (stage_valid == 3'b000) break;
            next_cycle();
        end
        check(tag, stage_valid, 3'b000);
    endtask

    logic [2:0] st_valid [8] = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b111, 3'b110, 3'b100, 3'b000};
    logic       st_ret   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [IW-1:0] st_ins [4] = '{24'h100001, 24'h100002, 24'h100003, 24'h100004};

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        stage_done = 3'b000;
        idle();

        // ---------------- reset state ----------------
        @(posedge clk);
        #2;
        check("rst_valid",    stage_valid, 3'b000);
        check("rst_instr",    stage_instr, '0);
        check("rst_in_ready", in_ready,    1'b1);
        check("rst_hazard",   hazard,      1'b0);
        check("rst_issue_go", issue_go,    1'b0);
        check("rst_retire",   retire,      1'b0);
        rst = 1'b0;

        // ---------------- streaming, 4 back-to-back ----------------
        for (int c = 0; c < 8; c++) begin
            stage_done = 3'b111;
            if (c < 4) drive(1'b1, st_ins[c], '0, '0, 1'b0, 1'b0);
            else       idle();
            #1;
            check($sformatf("stream_valid_c%0d", c), stage_valid, st_valid[c]);
            check($sformatf("stream_retire_c%0d", c), retire, st_ret[c]);
            check($sformatf("stream_ready_c%0d", c), in_ready, 1'b1);
            if (c == 3) check("stream_instr_c3", stage_instr, {st_ins[0], st_ins[1], st_ins[2]});
            next_cycle();
        end

        // ---------------- RAW hazard ----------------
        drive(1'b1, 24'hA0000A, 8'h00, 8'h04, 1'b0, 1'b0);   // A writes r2
        #1;
        check("raw_c0_ready", in_ready, 1'b1);
        next_cycle();
        drive(1'b1, 24'hB0000B, 8'h04, 8'h00, 1'b0, 1'b0);   // B reads r2
        #1;
        check("raw_c1_go",     issue_go, 1'b1);
        check("raw_c1_hazard", hazard,   1'b0);
        check("raw_c1_ready",  in_ready, 1'b1);
        next_cycle();
        idle();
        #1;
        check("raw_c2_valid",  stage_valid, 3'b011);
        check("raw_c2_hazard", hazard,      1'b1);
        check("raw_c2_go",     issue_go,    1'b0);
        check("raw_c2_ready",  in_ready,    1'b0);
        next_cycle();
        #1;
        check("raw_c3_valid",  stage_valid, 3'b101);
        check("raw_c3_retire", retire,      1'b1);
        check("raw_c3_hazard", hazard,      !BYP);
        check("raw_c3_go",     issue_go,    BYP);
        next_cycle();
        #1;
        check("raw_c4_valid",  stage_valid, BYP ? 3'b010 : 3'b001);
        check("raw_c4_hazard", hazard,      1'b0);
        check("raw_c4_go",     issue_go,    !BYP);
        drain("raw_drain");

        // ---------------- flag hazard ----------------
        drive(1'b1, 24'hF00001, 8'h00, 8'h00, 1'b0, 1'b1);   // A sets flags
        #1;
        next_cycle();
        drive(1'b1, 24'hF00002, 8'h00, 8'h00, 1'b1, 1'b0);   // B uses flags
        #1;
        check("flag_c1_go", issue_go, 1'b1);
        next_cycle();
        idle();
        #1;
        check("flag_c2_valid",  stage_valid, 3'b011);
        check("flag_c2_hazard", hazard,      1'b1);
        next_cycle();
        #1;
        check("flag_c3_valid",  stage_valid, 3'b101);
        check("flag_c3_hazard", hazard,      1'b1);
        check("flag_c3_go",     issue_go,    1'b0);
        next_cycle();
        #1;
        check("flag_c4_valid",  stage_valid, 3'b001);
        check("flag_c4_hazard", hazard,      1'b0);
        check("flag_c4_go",     issue_go,    1'b1);
        drain("flag_drain");

        // ---------------- backpressure on writeback ----------------
        stage_done = 3'b011;
        drive(1'b1, 24'hC00000, '0, '0, 1'b0, 1'b0);
        #1;
        check("bp_c0_ready", in_ready, 1'b1);
        next_cycle();
        drive(1'b1, 24'hC00001, '0, '0, 1'b0, 1'b0);
        #1;
        next_cycle();
        drive(1'b1, 24'hC00002, '0, '0, 1'b0, 1'b0);
        #1;
        check("bp_c2_ready", in_ready, 1'b1);
        next_cycle();
        drive(1'b1, 24'hC00003, '0, '0, 1'b0, 1'b0);
        #1;
        check("bp_c3_valid",  stage_valid, 3'b111);
        check("bp_c3_ready",  in_ready,    1'b0);
        check("bp_c3_retire", retire,      1'b0);
        check("bp_c3_instr",  stage_instr, {24'hC00000, 24'hC00001, 24'hC00002});
        next_cycle();
        #1;
        check("bp_c4_instr",  stage_instr, {24'hC00000, 24'hC00001, 24'hC00002});
        check("bp_c4_ready",  in_ready,    1'b0);
        next_cycle();
        stage_done = 3'b111;
        #1;
        check("bp_c5_retire", retire,   1'b1);
        check("bp_c5_ready",  in_ready, 1'b1);
        next_cycle();
        idle();
        #1;
        check("bp_c6_valid", stage_valid, 3'b111);
        check("bp_c6_instr", stage_instr, {24'hC00001, 24'hC00002, 24'hC00003});
        next_cycle();
        #1;
        check("bp_c7_valid", stage_valid, 3'b110);
        check("bp_c7_s1",    stage_instr[IW +: IW],   24'hC00003);
        check("bp_c7_s2",    stage_instr[2*IW +: IW], 24'hC00002);
        drain("bp_drain");

        // ---------------- flush ----------------
        stage_done = 3'b111;
        drive(1'b1, 24'h111111, '0, '0, 1'b0, 1'b0);
        #1;
        next_cycle();
        drive(1'b1, 24'h222222, '0, '0, 1'b0, 1'b0);
        #1;
        next_cycle();
        drive(1'b1, 24'hABCDEF, '0, '0, 1'b0, 1'b0);
        #1;
        next_cycle();
        stage_done = 3'b000;
        flush      = 1'b1;
        drive(1'b1, 24'h123456, '0, '0, 1'b0, 1'b0);
        #1;
        check("fl_c3_valid", stage_valid,         3'b111);
        check("fl_c3_s0",    stage_instr[0 +: IW], 24'hABCDEF);
        check("fl_c3_ready", in_ready,            1'b0);
        check("fl_c3_go",    issue_go,            1'b0);
        next_cycle();
        flush = 1'b0;
        idle();
        #1;
        check("fl_c4_valid", stage_valid,             3'b110);
        check("fl_c4_s1",    stage_instr[IW +: IW],   24'h222222);
        check("fl_c4_s2",    stage_instr[2*IW +: IW], 24'h111111);
        check("fl_c4_ready", in_ready,                1'b1);
        next_cycle();

        // ---------------- async reset mid-stream ----------------
        stage_done = 3'b111;
        #1;
        check("ar_pre_valid",  stage_valid, 3'b110);
        check("ar_pre_retire", retire,      1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("ar_valid",  stage_valid, 3'b000);
        check("ar_retire", retire,      1'b0);
        rst = 1'b0;
        #1;
        check("ar_rel_ready",  in_ready, 1'b1);
        check("ar_rel_hazard", hazard,   1'b0);
        check("ar_rel_go",     issue_go, 1'b0);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
